// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// alu_arbiter_if : request, response and ALU-side signals of alu_arbiter
// Revision 1.0
// ============================================================================
interface alu_arbiter_if #(
    parameter int N = 32
);
    logic         req0_valid;
    logic         req1_valid;
    logic         req0_ready;
    logic         req1_ready;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic [3:0]   req0_ctrl;
    logic [3:0]   req1_ctrl;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [N-1:0] rsp_y;
    logic [3:0]   rsp_flags;

    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_ctrl;
    logic [N-1:0] alu_y;
    logic [3:0]   alu_flags;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_ctrl, req1_ctrl, rsp_ready, alu_y, alu_flags,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_y, rsp_flags,
               alu_a, alu_b, alu_ctrl
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_ctrl, req1_ctrl, rsp_ready, alu_y, alu_flags,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_y, rsp_flags,
               alu_a, alu_b, alu_ctrl
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// alu_arbiter : shares one combinational ALU between two requesters
//               (IDLE -> EXEC -> RESP), response tagged with requester id.
//               Define ALU_ARB_FIXED_PRIO_EN for fixed priority to requester 0.
// Revision 1.0
// ============================================================================
module alu_arbiter #(
    parameter int N = 32
) (
    input  wire logic    clk,
    input  wire logic    reset,
    alu_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]   state_q,     state_d;
    logic [N-1:0] op_a_q,      op_a_d;
    logic [N-1:0] op_b_q,      op_b_d;
    logic [3:0]   op_ctrl_q,   op_ctrl_d;
    logic         op_id_q,     op_id_d;
    logic         rsp_id_q,    rsp_id_d;
    logic [N-1:0] rsp_y_q,     rsp_y_d;
    logic [3:0]   rsp_flags_q, rsp_flags_d;

    logic any_valid;
    logic win_id;

    assign any_valid = bus.req0_valid | bus.req1_valid;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign win_id = ~bus.req0_valid & bus.req1_valid;
`else
    logic last_grant_q, last_grant_d;

    // On contention the requester that did not win last time goes next
    assign win_id = (bus.req0_valid & bus.req1_valid) ? ~last_grant_q : bus.req1_valid;

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == S_IDLE && any_valid) begin
            last_grant_d = win_id;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_ctrl_d   = op_ctrl_q;
        op_id_d     = op_id_q;
        rsp_id_d    = rsp_id_q;
        rsp_y_d     = rsp_y_q;
        rsp_flags_d = rsp_flags_q;
        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    op_a_d    = win_id ? bus.req1_a    : bus.req0_a;
                    op_b_d    = win_id ? bus.req1_b    : bus.req0_b;
                    op_ctrl_d = win_id ? bus.req1_ctrl : bus.req0_ctrl;
                    op_id_d   = win_id;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_y_d     = bus.alu_y;
                rsp_flags_d = bus.alu_flags;
                rsp_id_d    = op_id_q;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_ctrl_q   <= 4'b0000;
            op_id_q     <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_y_q     <= '0;
            rsp_flags_q <= 4'b0000;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_ctrl_q   <= op_ctrl_d;
            op_id_q     <= op_id_d;
            rsp_id_q    <= rsp_id_d;
            rsp_y_q     <= rsp_y_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    assign bus.req0_ready = (state_q == S_IDLE) & any_valid & ~win_id;
    assign bus.req1_ready = (state_q == S_IDLE) & any_valid &  win_id;

    // Operand registers feed the ALU directly so its inputs only move on accept
    assign bus.alu_a     = op_a_q;
    assign bus.alu_b     = op_b_q;
    assign bus.alu_ctrl  = op_ctrl_q;

    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_flags = rsp_flags_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// tb_alu_arbiter : directed scoreboard bench for alu_arbiter with an ALU model
// Revision 1.0
// ============================================================================
module tb_alu_arbiter;
    typedef struct packed {
        logic        id;
        logic [3:0]  f;
        logic [31:0] y;
    } rsp_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   cyc;
    int   n_acc;
    int   n_rsp;
    int   acc_cyc;
    int   hs_cyc;
    logic last_acc_id;
    logic prev_rv;
    rsp_t sb[$];
    rsp_t got[$];

    alu_arbiter_if #(.N(32)) bus ();

    alu_arbiter #(.N(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] c);
        logic [32:0] s;
        logic [31:0] y;
        logic        cf;
        logic        vf;
        s  = '0;
        y  = '0;
        cf = 1'b0;
        vf = 1'b0;
        case (c)
            4'b0000: begin
                s  = {1'b0, a} + {1'b0, b};
                y  = s[31:0];
                cf = s[32];
                vf = (a[31] == b[31]) && (y[31] != a[31]);
            end
            4'b0010: y = a & b;
            4'b0011: y = a | b;
            4'b0100: y = a ^ b;
            default: y = '0;
        endcase
        return {y[31], (y == 32'd0), cf, vf, y};
    endfunction

    assign {bus.alu_flags, bus.alu_y} = alu_model(bus.alu_a, bus.alu_b, bus.alu_ctrl);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic rsp_t mk_exp(input logic id, input logic [31:0] a, input logic [31:0] b,
                                    input logic [3:0] c);
        logic [35:0] m;
        rsp_t        e;
        m    = alu_model(a, b, c);
        e.id = id;
        e.f  = m[35:32];
        e.y  = m[31:0];
        return e;
    endfunction

    // Handshake monitor: push on accept, pop and compare on response handshake
    always @(negedge clk) begin
        rsp_t e;
        if (!reset) begin
            if (bus.rsp_valid) begin
                if (!prev_rv) begin
                    n_tests++;
                    assert ((cyc - acc_cyc) == 2) else begin
                        n_fail++;
                        $error("FAIL latency obs=%0d exp=2", cyc - acc_cyc);
                    end
                end
                n_tests++;
                assert ({bus.req0_ready, bus.req1_ready} === 2'b00) else begin
                    n_fail++;
                    $error("FAIL ready_in_resp obs=%b exp=00", {bus.req0_ready, bus.req1_ready});
                end
                if (bus.rsp_ready) begin
                    n_tests++;
                    assert (sb.size() > 0) else begin
                        n_fail++;
                        $error("FAIL sb_empty obs=%0d exp=>0", sb.size());
                    end
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        n_tests++;
                        assert ({bus.rsp_id, bus.rsp_flags, bus.rsp_y} === e) else begin
                            n_fail++;
                            $error("FAIL sb_rsp obs=%0h exp=%0h",
                                   {bus.rsp_id, bus.rsp_flags, bus.rsp_y}, e);
                        end
                    end
                    got.push_back({bus.rsp_id, bus.rsp_flags, bus.rsp_y});
                    hs_cyc = cyc;
                    n_rsp++;
                end
            end
            if (bus.req0_valid && bus.req0_ready) begin
                sb.push_back(mk_exp(1'b0, bus.req0_a, bus.req0_b, bus.req0_ctrl));
                n_acc++;
                acc_cyc     = cyc;
                last_acc_id = 1'b0;
            end
            if (bus.req1_valid && bus.req1_ready) begin
                sb.push_back(mk_exp(1'b1, bus.req1_a, bus.req1_b, bus.req1_ctrl));
                n_acc++;
                acc_cyc     = cyc;
                last_acc_id = 1'b1;
            end
            prev_rv = bus.rsp_valid;
        end else begin
            prev_rv = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_acc(input int target);
        int t;
        t = 0;
        while (n_acc < target && t < 200) begin
            tick();
            t++;
        end
        chk("acc_timeout", 64'(n_acc >= target), 64'd1);
    endtask

    task automatic wait_rsp(input int target);
        int t;
        t = 0;
        while (n_rsp < target && t < 200) begin
            tick();
            t++;
        end
        chk("rsp_timeout", 64'(n_rsp >= target), 64'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        sb.delete();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int base;
        n_tests = 0; n_fail = 0; n_acc = 0; n_rsp = 0;
        acc_cyc = 0; hs_cyc = 0; last_acc_id = 1'b0; prev_rv = 1'b0;
        reset = 1'b1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_a = '0; bus.req0_b = '0; bus.req0_ctrl = '0;
        bus.req1_a = '0; bus.req1_b = '0; bus.req1_ctrl = '0;
        bus.rsp_ready = 1'b1;
        tick();
        tick();
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp", 64'({bus.rsp_id, bus.rsp_flags, bus.rsp_y}), 64'd0);
        chk("rst_alu", 64'({bus.alu_ctrl, bus.alu_a, bus.alu_b}), 64'd0);
        reset = 1'b0;
        tick();
        chk("idle_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);

        // Single request
        bus.req0_a = 32'd5; bus.req0_b = 32'd3; bus.req0_ctrl = 4'b0000;
        bus.req0_valid = 1'b1;
        wait_acc(1);
        bus.req0_valid = 1'b0;
        wait_rsp(1);
        chk("single_y", 64'(got[0].y), 64'd8);
        chk("single_flags", 64'(got[0].f), 64'd0);
        chk("single_id", 64'(got[0].id), 64'd0);

        // Contention right after reset
        do_reset();
        base = n_rsp;
        bus.req0_a = 32'hF0; bus.req0_b = 32'h3C; bus.req0_ctrl = 4'b0010;
        bus.req1_a = 32'h01; bus.req1_b = 32'h02; bus.req1_ctrl = 4'b0011;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        wait_acc(n_acc + 1);
        if (last_acc_id) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
        wait_acc(n_acc + 1);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        wait_rsp(base + 2);
        chk("cont_id0", 64'(got[base].id), 64'd0);
        chk("cont_y0", 64'(got[base].y), 64'h30);
        chk("cont_id1", 64'(got[base+1].id), 64'd1);
        chk("cont_y1", 64'(got[base+1].y), 64'h03);

        // Both held valid for four operations
        base = n_rsp;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        wait_acc(n_acc + 4);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        wait_rsp(base + 4);
`ifdef ALU_ARB_FIXED_PRIO_EN
        chk("rr_ids", 64'({got[base].id, got[base+1].id, got[base+2].id, got[base+3].id}), 64'b0000);
`else
        chk("rr_ids", 64'({got[base].id, got[base+1].id, got[base+2].id, got[base+3].id}), 64'b0101);
`endif

        // Backpressure in RESP with a competing request waiting
        base = n_rsp;
        bus.rsp_ready = 1'b0;
        bus.req0_a = 32'h0000AA55; bus.req0_b = 32'h00000FF0; bus.req0_ctrl = 4'b0100;
        bus.req0_valid = 1'b1;
        wait_acc(n_acc + 1);
        bus.req0_valid = 1'b0;
        bus.req1_a = 32'd1; bus.req1_b = 32'd2; bus.req1_ctrl = 4'b0000;
        bus.req1_valid = 1'b1;
        for (int t = 0; t < 20 && !bus.rsp_valid; t++) tick();
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("bp_hold", 64'({bus.rsp_id, bus.rsp_flags, bus.rsp_y}), 64'h0_0_0000A5A5);
            chk("bp_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        wait_acc(n_acc + 1);
        bus.req1_valid = 1'b0;
        chk("bp_reaccept", 64'(acc_cyc - hs_cyc), 64'd1);
        wait_rsp(base + 2);
        chk("bp_y1", 64'(got[base+1].y), 64'd3);

        // Flags: wrap-around add from requester 1
        base = n_rsp;
        bus.req1_a = 32'hFFFFFFFF; bus.req1_b = 32'd1; bus.req1_ctrl = 4'b0000;
        bus.req1_valid = 1'b1;
        wait_acc(n_acc + 1);
        bus.req1_valid = 1'b0;
        wait_rsp(base + 1);
        chk("flags_y", 64'(got[base].y), 64'd0);
        chk("flags_nzcv", 64'(got[base].f), 64'b0110);
        chk("flags_id", 64'(got[base].id), 64'd1);

        // Reset asserted during EXEC discards the operation
        bus.req0_a = 32'd7; bus.req0_b = 32'd9; bus.req0_ctrl = 4'b0000;
        bus.req0_valid = 1'b1;
        wait_acc(n_acc + 1);
        bus.req0_valid = 1'b0;
        chk("exec_alu_a", 64'(bus.alu_a), 64'd7);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_exec_alu", 64'({bus.alu_a, bus.alu_b}), 64'd0);
        chk("rst_exec_valid", 64'(bus.rsp_valid), 64'd0);
        base = n_rsp;
        tick();
        sb.delete();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_valid", 64'(bus.rsp_valid), 64'd0);
        end
        bus.req0_a = 32'd2; bus.req0_b = 32'd2; bus.req0_ctrl = 4'b0000;
        bus.req1_a = 32'd4; bus.req1_b = 32'd4; bus.req1_ctrl = 4'b0000;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        wait_acc(n_acc + 1);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        chk("post_rst_winner", 64'(last_acc_id), 64'd0);
        wait_rsp(base + 1);
        chk("post_rst_y", 64'(got[base].y), 64'd4);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencer that shares one combinational ALU datapath between two requesters, for example the execute stage and a multi-cycle helper unit.
- Arbitrates between two operand/ALUControl requests.
- Registers the winning operands and drives them into the ALU.
- Captures the ALU result and NZCV flags.
- Returns them through a valid/ready response channel tagged with the requester id.
- Sits between the requesters and the ALU block that selects among the sum/logic/shift results by ALUControl.

## Interface
Parameters:
- N, default 32: operand/result width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid, req1_valid  in  1  request present; held until accepted.
- req0_ready, req1_ready  out  1  request accepted this cycle when valid&ready.
- req0_a, req0_b, req1_a, req1_b  in  N  operands.
- req0_ctrl, req1_ctrl  in  4  ALUControl code, passed through unmodified; all 16 codes are legal.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that issued the response (0/1).
- rsp_y  out  N  captured ALU result.
- rsp_flags  out  4  captured ALU flags {N,Z,C,V}.
- alu_a, alu_b  out  N  registered operands to the ALU.
- alu_ctrl  out  4  registered ALUControl to the ALU.
- alu_y  in  N  ALU result (combinational from alu_a/alu_b/alu_ctrl).
- alu_flags  in  4  ALU flags {N,Z,C,V}.

## Operation
States: IDLE, EXEC, RESP.

IDLE
- Winner selection:
  - If exactly one reqX_valid is high, that requester wins.
  - If both are high, the requester != last_grant wins.
- reqX_ready is asserted combinationally only for the winner, and only in IDLE.
- On accept:
  - Load op_a, op_b, op_ctrl and op_id from the winner.
  - Set last_grant = winner.
  - Go to EXEC.
- With no valid request, stay in IDLE.

EXEC
- alu_a/alu_b/alu_ctrl are driven from op_a/op_b/op_ctrl. They are always register-driven and hold their last values outside EXEC.
- At the cycle end:
  - rsp_y <= alu_y, rsp_flags <= alu_flags, rsp_id <= op_id.
  - Go to RESP.

RESP
- rsp_valid=1; rsp_y, rsp_flags and rsp_id stay stable until the handshake.
- On rsp_valid&rsp_ready, go to IDLE. Otherwise hold.
- Both reqX_ready=0.

Rules
- reqX_ready is never high outside IDLE. A requester dropping valid before accept is legal; no state changes.
- last_grant changes only on accept, so the winner stays stable while requests are held.
- No width conversion: alu_y is N bits; flags come straight from the ALU.

Reset (any state, asynchronous)
- State goes to IDLE and any in-flight operation is discarded without a response.
- last_grant=1, so requester 0 wins first.
- rsp_valid=0, rsp_id=0, rsp_y=0, rsp_flags=0.
- alu_a=0, alu_b=0, alu_ctrl=4'b0000.
- reqX_ready follows IDLE rules once reset deasserts.

## Timing
- Cycle 0: accept in IDLE.
- Cycle 1: EXEC; ALU inputs change at the start of the cycle, result sampled at the end.
- Cycle 2: rsp_valid=1.
- Latency from accept to rsp_valid is 2 cycles.
- If rsp_ready is high in cycle 2, IDLE is reached in cycle 3 and the next accept can happen in cycle 3. Peak throughput is 1 operation per 3 cycles.
- No bypass: an accept and a response handshake never occur in the same cycle.
- The ALU path is combinational within one cycle: alu_* to alu_y must meet the clk period.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: requester 0 always wins when both are valid; last_grant is unused.
- ALU_ARB_FIXED_PRIO_EN undefined (default): round-robin as above.

## Test plan
Bench models the ALU: 0000 add, 0010 and, 0011 or, 0100 xor, with flags.
- Single request: req0 a=5, b=3, ctrl=0000 -> rsp_valid exactly 2 cycles after accept, rsp_y=8, flags=0000, rsp_id=0.
- Contention after reset: both valid; req0 ctrl=0010 a=0xF0 b=0x3C; req1 ctrl=0011 a=0x01 b=0x02 -> first response id 0 y=0x30, second id 1 y=0x03.
- Round-robin: both held valid for 4 ops -> ids 0,1,0,1. With ALU_ARB_FIXED_PRIO_EN the same stimulus gives 0,0,0,0.
- Backpressure: rsp_ready low 4 cycles in RESP -> rsp_y/rsp_id/rsp_flags stable, req0_ready=req1_ready=0; raise rsp_ready -> IDLE next cycle, new accept that cycle.
- Flags: req1 a=0xFFFFFFFF, b=1, ctrl=0000 -> y=0, flags Z=1 C=1, rsp_id=1.
- Reset in EXEC: assert reset mid-cycle 1 -> rsp_valid stays 0, alu_a=alu_b=0 immediately; after release, req0 wins contention first.
